// File: rtl/rfft_pkg.sv
// Shared constants, state encoding and address helpers for the 256-point
// in-place radix-2 RFFT stage/address sequencer.
package rfft_pkg;

  localparam int AW     = 6;
  localparam int NSTAGE = AW + 1;
  localparam int LIMIT  = (2 ** AW) - 1;
  localparam int PE_LAT = 2;
  localparam int TF_AW  = 8;
  localparam int DLY_W  = 2 + 2 * AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mask covering the top s bits of a bank address (the bits inverted for
  // the partner bank pair at stage s).
  function automatic logic [AW-1:0] inv_mask(input logic [2:0] s);
    logic [AW-1:0] m;
    m = '0;
    for (int i = 0; i < AW; i++) begin
      if (i >= AW - int'(s)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/rfft_seq_dly.sv
// Fixed-depth delay line aligning write-side controls with the PE output;
// cleared synchronously by reset.
module rfft_seq_dly #(
  parameter int W     = 14,
  parameter int DEPTH = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_r [DEPTH];

  // Shift register stages; reset empties the line so no stale write fires.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/rfft_seq.sv
// Stage/address sequencer: drives bank read/write addresses, lane swaps,
// twiddle address and bypass for the in-place radix-2 RFFT datapath.
module rfft_seq
  import rfft_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stage,
  output logic [AW-1:0]    rd_addr0,
  output logic [AW-1:0]    rd_addr1,
  output logic             rd_swap,
  output logic [TF_AW-1:0] tf_addr,
  output logic             bypass_n,
  output logic             we,
  output logic [AW-1:0]    wr_addr0,
  output logic [AW-1:0]    wr_addr1,
  output logic             wr_swap
);

  state_t          state_r, state_s;
  logic [AW-1:0]   cnt_r, cnt_s;
  logic [2:0]      stage_r, stage_s;
  logic            run_s;
  logic            wr_bit_s;
  logic [AW-1:0]   mask_s;
  logic [AW-1:0]   rd_sh_s;
  logic [AW-1:0]   wr_sh_s;
  logic [DLY_W-1:0] dly_in_s;
  logic [DLY_W-1:0] dly_out_s;

  // State, counter and stage registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      stage_r <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stage_r <= stage_s;
    end
  end

  // Next-state logic; cnt doubles as the drain-gap counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stage_s = stage_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_RUN;
          cnt_s   = '0;
          stage_s = 3'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (cnt_r == AW'(LIMIT)) begin
          state_s = ST_DRAIN;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_r == AW'(PE_LAT - 1)) begin
          cnt_s = '0;
          if (stage_r == 3'(NSTAGE - 1)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
            stage_s = stage_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + AW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        stage_s = 3'd0;
      end
    endcase
  end

  // Read-side decode from the registered counter and stage.
  always_comb begin
    run_s   = (state_r == ST_RUN);
    mask_s  = inv_mask(stage_r);
    rd_sh_s = cnt_r >> (3'(AW) - stage_r);
    wr_sh_s = cnt_r >> (3'(AW - 1) - stage_r);
    if (run_s) begin
      rd_addr0 = cnt_r;
      rd_addr1 = cnt_r ^ mask_s;
      tf_addr  = TF_AW'(cnt_r & ~mask_s) << stage_r;
      if (stage_r == 3'd0) begin
        rd_swap = 1'b0;
      end else begin
        rd_swap = rd_sh_s[0];
      end
      if (stage_r == 3'(NSTAGE - 1)) begin
        wr_bit_s = 1'b0;
      end else begin
        wr_bit_s = wr_sh_s[0];
      end
    end else begin
      rd_addr0 = '0;
      rd_addr1 = '0;
      tf_addr  = '0;
      rd_swap  = 1'b0;
      wr_bit_s = 1'b0;
    end
    bypass_n = (stage_r != 3'(NSTAGE - 1));
  end

  assign busy     = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign done     = (state_r == ST_DONE);
  assign stage    = stage_r;
  assign dly_in_s = {run_s, rd_addr0, rd_addr1, wr_bit_s};

  rfft_seq_dly #(
    .W     (DLY_W),
    .DEPTH (PE_LAT)
  ) u_dly (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .din     (dly_in_s),
    .dout    (dly_out_s)
  );

  assign we       = dly_out_s[DLY_W-1];
  assign wr_addr0 = we ? dly_out_s[2*AW:AW+1] : '0;
  assign wr_addr1 = we ? dly_out_s[AW:1]      : '0;
  assign wr_swap  = we ? dly_out_s[0]         : 1'b0;

endmodule
